// File: rtl/sym_vn_lut_loader.sv
// sym_vn_lut_loader: streams one LUT_DEPTH-entry VN IB-LUT page set into the LUT write port per load.
// Define SYM_VN_LUT_LOAD_CHK_EN to expect a trailing modulo-2^DATA_W checksum beat per load.
module sym_vn_lut_loader #(
    parameter int LUT_DEPTH = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 3,
    parameter int ITER_NUM  = 10
) (
    input  logic              write_clk,
    input  logic              rstn,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] lut_in_bank0,
    output logic [ADDR_W-1:0] page_write_addr,
    output logic              we,
    output logic [3:0]        iter_id,
    output logic              load_busy,
    output logic              load_done,
    output logic              chk_err
);
    typedef enum logic [1:0] {IDLE, LOAD, CHK, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic wr_acc;
    logic last;

    assign wr_acc = in_valid && in_ready && state == LOAD;
    assign last   = cnt == ADDR_W'(LUT_DEPTH - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = load_start ? LOAD : IDLE;
`ifdef SYM_VN_LUT_LOAD_CHK_EN
            LOAD: state_nx = (wr_acc && last) ? CHK : LOAD;
`else
            LOAD: state_nx = (wr_acc && last) ? DONE : LOAD;
`endif
            CHK:  state_nx = (in_valid && in_ready) ? DONE : CHK;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Handshake/status flags are registered from the next state so they line up with it.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            in_ready        <= 1'b0;
            load_busy       <= 1'b0;
            load_done       <= 1'b0;
            we              <= 1'b0;
            lut_in_bank0    <= '0;
            page_write_addr <= '0;
            cnt             <= '0;
            iter_id         <= '0;
        end else begin
            in_ready  <= state_nx == LOAD || state_nx == CHK;
            load_busy <= state_nx != IDLE;
            load_done <= state == DONE;
            we        <= wr_acc;
            if (wr_acc) begin
                lut_in_bank0    <= in_data;
                page_write_addr <= cnt;
            end
            cnt <= (state == IDLE) ? '0 : wr_acc ? cnt + ADDR_W'(1) : cnt;
            if (state == DONE)
                iter_id <= (iter_id == 4'(ITER_NUM - 1)) ? 4'd0 : iter_id + 4'd1;
        end
    end

`ifdef SYM_VN_LUT_LOAD_CHK_EN
    logic [DATA_W-1:0] sum;
    logic              chk_bad;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            sum     <= '0;
            chk_bad <= 1'b0;
            chk_err <= 1'b0;
        end else begin
            sum <= (state == IDLE) ? '0 : wr_acc ? sum + in_data : sum;
            if (state == CHK && in_valid && in_ready) chk_bad <= in_data != sum;
            if (state == DONE) chk_err <= chk_bad;
        end
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// tb_sym_vn_lut_loader: directed bench for sym_vn_lut_loader (default build; checksum cases under the macro).
module tb_sym_vn_lut_loader;
    localparam int DEPTH = 32;
`ifdef SYM_VN_LUT_LOAD_CHK_EN
    localparam int CHK_LAT = 1;
`else
    localparam int CHK_LAT = 0;
`endif

    logic       write_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       load_start = 1'b0;
    logic [2:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] lut_in_bank0;
    logic [4:0] page_write_addr;
    logic       we;
    logic [3:0] iter_id;
    logic       load_busy;
    logic       load_done;
    logic       chk_err;

    int checks = 0, errors = 0, cyc = 0;
    int wr_cnt = 0, done_cnt = 0, first_we = -1, last_we = -1, done_cyc = -1, start_cyc = 0;
    int dmul = 1, dadd = 0, chk_override = -1, exp_iter = 0;

    sym_vn_lut_loader dut (
        .write_clk(write_clk), .rstn(rstn), .load_start(load_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .lut_in_bank0(lut_in_bank0),
        .page_write_addr(page_write_addr), .we(we), .iter_id(iter_id),
        .load_busy(load_busy), .load_done(load_done), .chk_err(chk_err)
    );

    always #5 write_clk = ~write_clk;
    always @(posedge write_clk) cyc <= cyc + 1;

    function automatic logic [2:0] f(int i);
        return 3'((i * dmul + dadd) % 8);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    always @(negedge write_clk) begin
        if (we) begin
            check("wr_addr", 32'(page_write_addr), 32'(wr_cnt));
            check("wr_data", 32'(lut_in_bank0), 32'(f(wr_cnt)));
            if (wr_cnt == 0) first_we = cyc;
            last_we = cyc;
            wr_cnt++;
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        exp_iter = 0;
    endtask

    task automatic send_load(input bit gap, input bit mid);
        int i, g, s;
        bit acc;
        wr_cnt = 0;
        first_we = -1;
        start_cyc = cyc;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("start_ready", 32'(in_ready), 1);
        check("start_busy", 32'(load_busy), 1);
        i = 0;
        g = 0;
        s = 0;
        while (i < DEPTH && g < 400) begin
            in_valid = gap ? (g % 2 == 0) : 1'b1;
            in_data = f(i);
            load_start = mid && i == 5;
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                s += int'(f(i));
                i++;
            end
            g++;
        end
        load_start = 1'b0;
`ifdef SYM_VN_LUT_LOAD_CHK_EN
        in_valid = 1'b1;
        in_data = (chk_override < 0) ? 3'(s % 8) : 3'(chk_override);
        while (!in_ready && g < 400) begin
            tick();
            g++;
        end
        tick();
`endif
        in_valid = 1'b0;
        if (g >= 400) check("beat_timeout", 32'(i), DEPTH);
        g = 0;
        while (!load_done && g < 10) begin
            tick();
            g++;
        end
        check("done_seen", 32'(load_done), 1);
        check("done_busy", 32'(load_busy), 0);
        exp_iter = (exp_iter + 1) % 10;
        check("iter_id", 32'(iter_id), 32'(exp_iter));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int d0, w0;
        #2;
        check("rst_ready", 32'(in_ready), 0);
        check("rst_we", 32'(we), 0);
        check("rst_data", 32'(lut_in_bank0), 0);
        check("rst_addr", 32'(page_write_addr), 0);
        check("rst_iter", 32'(iter_id), 0);
        check("rst_busy", 32'(load_busy), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_chk", 32'(chk_err), 0);
        do_reset();

        // full-rate load, data = addr mod 8
        dmul = 1; dadd = 0;
        send_load(1'b0, 1'b0);
        check("full_writes", 32'(wr_cnt), DEPTH);
        check("full_first_we", 32'(first_we), 32'(start_cyc + 2));
        check("full_last_we", 32'(last_we), 32'(start_cyc + 33));
        check("full_done_cyc", 32'(done_cyc), 32'(start_cyc + 34 + CHK_LAT));
        check("full_done_cnt", 32'(done_cnt), 1);

        // in_valid while idle must not write
        wr_cnt = 0;
        in_valid = 1'b1;
        in_data = 3'd6;
        repeat (4) tick();
        in_valid = 1'b0;
        tick();
        check("idle_no_write", 32'(wr_cnt), 0);
        check("idle_ready", 32'(in_ready), 0);

        // gapped valid
        dmul = 3; dadd = 5;
        send_load(1'b1, 1'b0);
        check("gap_writes", 32'(wr_cnt), DEPTH);

        // load_start mid-load is ignored
        dmul = 1; dadd = 2;
        d0 = done_cnt;
        send_load(1'b0, 1'b1);
        check("mid_writes", 32'(wr_cnt), DEPTH);
        repeat (6) tick();
        check("mid_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        check("mid_no_queue", 32'(in_ready), 0);
        check("mid_iter", 32'(iter_id), 3);

        // reset after entry 12
        dmul = 1; dadd = 0;
        wr_cnt = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_data = f(i);
            tick();
        end
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_we", 32'(we), 0);
        check("arst_ready", 32'(in_ready), 0);
        check("arst_addr", 32'(page_write_addr), 0);
        check("arst_data", 32'(lut_in_bank0), 0);
        check("arst_iter", 32'(iter_id), 0);
        check("arst_busy", 32'(load_busy), 0);
        tick();
        rstn = 1'b1;
        tick();
        exp_iter = 0;
        send_load(1'b0, 1'b0);
        check("after_rst_writes", 32'(wr_cnt), DEPTH);
        check("after_rst_iter", 32'(iter_id), 1);

        // ten back-to-back loads: iter_id 1..9,0
        do_reset();
        d0 = done_cnt;
        for (int k = 0; k < 10; k++) begin
            dmul = 5; dadd = k;
            send_load(1'b0, 1'b0);
            check("b2b_writes", 32'(wr_cnt), DEPTH);
        end
        check("b2b_done_cnt", 32'(done_cnt), 32'(d0 + 10));
        check("b2b_iter_wrap", 32'(iter_id), 0);

`ifdef SYM_VN_LUT_LOAD_CHK_EN
        dmul = 0; dadd = 1;
        chk_override = 0;
        send_load(1'b0, 1'b0);
        check("chk_ok", 32'(chk_err), 0);
        chk_override = 3;
        send_load(1'b0, 1'b0);
        check("chk_bad", 32'(chk_err), 1);
        repeat (3) tick();
        check("chk_hold", 32'(chk_err), 1);
        chk_override = -1;
`else
        w0 = 0;
        check("chk_tied", 32'(chk_err), 32'(w0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
